// File: rtl/risc_pkg.sv
// Shared encodings for the 16-bit RISC core controller: instruction fields,
// datapath select codes and the control FSM state set.
package risc_pkg;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_LDST    = 2'b00;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] WBS_C     = 2'b00;
   localparam logic [1:0] WBS_PC    = 2'b01;
   localparam logic [1:0] WBS_IMM8  = 2'b10;
   localparam logic [1:0] WBS_MDATA = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;

   typedef enum logic [2:0] {
      CLS_MOVI,
      CLS_MOVR,
      CLS_ALU,
      CLS_LDR,
      CLS_STR,
      CLS_HALT,
      CLS_ILL
   } iclass_t;

   typedef enum logic [3:0] {
      RST,
      FETCH,
      DECODE,
      WB_IMM,
      GET_A,
      GET_B,
      EXEC,
      WB,
      ADDR,
      LD_ADDR,
      MEM_RD,
      GET_D,
      MOV_D,
      MEM_WR,
      HALT
   } state_t;

endpackage

// File: rtl/instr_dec.sv
// Combinational IR decode: field extraction, immediate sign extension and
// instruction classification (undefined encodings report CLS_ILL).
module instr_dec
   import risc_pkg::*;
(
   input  logic [15:0] instr,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [1:0]  sh,
   output logic [2:0]  rm,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output iclass_t     cls
);

   logic [2:0] opcode;

   assign opcode = instr[15:13];
   assign op     = instr[12:11];
   assign rn     = instr[10:8];
   assign rd     = instr[7:5];
   assign sh     = instr[4:3];
   assign rm     = instr[2:0];
   assign sximm8 = {{8{instr[7]}}, instr[7:0]};
   assign sximm5 = {{11{instr[4]}}, instr[4:0]};

   always_comb begin
      cls = CLS_ILL;
      case (opcode)
         OPC_MOV: begin
            if (op == OP_MOV_IMM)
               cls = CLS_MOVI;
            else if (op == OP_MOV_REG)
               cls = CLS_MOVR;
         end
         OPC_ALU:  cls = CLS_ALU;
         OPC_LDR:  if (op == OP_LDST) cls = CLS_LDR;
         OPC_STR:  if (op == OP_LDST) cls = CLS_STR;
         OPC_HALT: cls = CLS_HALT;
         default:  cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch, decode and
// sequencing of every datapath, PC/IR and memory-handshake control.
module cpu_controller
   import risc_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        mem_ready,
   output logic        load_ir,
   output logic        en_pc,
   output logic        clr_pc,
   output logic        addr_sel,
   output logic        load_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [2:0]  w_addr,
   output logic [2:0]  r_addr,
   output logic        w_en,
   output logic [1:0]  wb_sel,
   output logic        en_A,
   output logic        en_B,
   output logic        en_C,
   output logic        en_status,
   output logic        sel_A,
   output logic        sel_B,
   output logic [1:0]  shift_op,
   output logic [1:0]  ALU_op,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic        halted
);

   state_t  state, next;
   iclass_t cls;
   logic [1:0] op, sh;
   logic [2:0] rn, rd, rm;
   logic is_cmp;

   instr_dec u_dec (
      .instr  (instr),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .sh     (sh),
      .rm     (rm),
      .sximm8 (sximm8),
      .sximm5 (sximm5),
      .cls    (cls)
   );

   assign is_cmp = (cls == CLS_ALU) && (op == ALU_SUB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RST;
      else
         state <= next;
   end

   always_comb begin
      next      = state;
      load_ir   = 1'b0;
      en_pc     = 1'b0;
      clr_pc    = 1'b0;
      addr_sel  = 1'b0;
      load_addr = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      w_addr    = '0;
      r_addr    = '0;
      w_en      = 1'b0;
      wb_sel    = WBS_C;
      en_A      = 1'b0;
      en_B      = 1'b0;
      en_C      = 1'b0;
      en_status = 1'b0;
      sel_A     = 1'b0;
      sel_B     = 1'b0;
      shift_op  = SH_NONE;
      ALU_op    = ALU_ADD;
      halted    = 1'b0;

      case (state)
         RST: begin
            clr_pc = 1'b1;
            en_pc  = 1'b1;
            next   = FETCH;
         end
         FETCH: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            if (mem_ready) begin
               load_ir = 1'b1;
               en_pc   = 1'b1;
               next    = DECODE;
            end
         end
         DECODE: begin
            case (cls)
               CLS_MOVI: next = WB_IMM;
               CLS_MOVR: next = GET_B;
               CLS_ALU, CLS_LDR, CLS_STR: next = GET_A;
               CLS_HALT: next = HALT;
               default:  next = HALT_ON_ILLEGAL ? HALT : FETCH;
            endcase
         end
         WB_IMM: begin
            w_addr = rn;
            wb_sel = WBS_IMM8;
            w_en   = 1'b1;
            next   = FETCH;
         end
         GET_A: begin
            r_addr = rn;
            en_A   = 1'b1;
            next   = (cls == CLS_ALU) ? GET_B : ADDR;
         end
         GET_B: begin
            r_addr = rm;
            en_B   = 1'b1;
            next   = EXEC;
         end
         EXEC: begin
            sel_B    = 1'b0;
            shift_op = sh;
            if (cls == CLS_ALU) begin
               sel_A  = 1'b1;
               ALU_op = op;
            end
            // CMP only updates status; nothing is written back
            if (is_cmp) begin
               en_status = 1'b1;
               next      = FETCH;
            end else begin
               en_C = 1'b1;
               next = WB;
            end
         end
         WB: begin
            w_addr = rd;
            wb_sel = WBS_C;
            w_en   = 1'b1;
            next   = FETCH;
         end
         ADDR: begin
            sel_A  = 1'b1;
            sel_B  = 1'b1;
            ALU_op = ALU_ADD;
            en_C   = 1'b1;
            next   = LD_ADDR;
         end
         LD_ADDR: begin
            load_addr = 1'b1;
            next      = (cls == CLS_LDR) ? MEM_RD : GET_D;
         end
         MEM_RD: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               w_en   = 1'b1;
               wb_sel = WBS_MDATA;
               w_addr = rd;
               next   = FETCH;
            end
         end
         GET_D: begin
            r_addr = rd;
            en_B   = 1'b1;
            next   = MOV_D;
         end
         MOV_D: begin
            en_C = 1'b1;
            next = MEM_WR;
         end
         MEM_WR: begin
            mem_wr = 1'b1;
            if (mem_ready)
               next = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: next = RST;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: one instance halts on illegal
// encodings, the other treats them as NOPs; both see identical stimulus.
module tb_cpu_controller;

   typedef struct packed {
      logic        load_ir, en_pc, clr_pc, addr_sel, load_addr, mem_rd, mem_wr;
      logic [2:0]  w_addr;
      logic [2:0]  r_addr;
      logic        w_en;
      logic [1:0]  wb_sel;
      logic        en_A, en_B, en_C, en_status, sel_A, sel_B;
      logic [1:0]  shift_op;
      logic [1:0]  ALU_op;
      logic [15:0] sximm8;
      logic [15:0] sximm5;
      logic        halted;
   } outs_t;

   typedef struct {
      outs_t e0;
      outs_t e1;
      string tag;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr;
   logic        mem_ready;

   logic [1:0]       load_ir, en_pc, clr_pc, addr_sel, load_addr, mem_rd, mem_wr;
   logic [1:0][2:0]  w_addr, r_addr;
   logic [1:0]       w_en;
   logic [1:0][1:0]  wb_sel;
   logic [1:0]       en_A, en_B, en_C, en_status, sel_A, sel_B;
   logic [1:0][1:0]  shift_op, ALU_op;
   logic [1:0][15:0] sximm8, sximm5;
   logic [1:0]       halted;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   cpu_controller #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
      .load_ir(load_ir[0]), .en_pc(en_pc[0]), .clr_pc(clr_pc[0]),
      .addr_sel(addr_sel[0]), .load_addr(load_addr[0]), .mem_rd(mem_rd[0]),
      .mem_wr(mem_wr[0]), .w_addr(w_addr[0]), .r_addr(r_addr[0]),
      .w_en(w_en[0]), .wb_sel(wb_sel[0]), .en_A(en_A[0]), .en_B(en_B[0]),
      .en_C(en_C[0]), .en_status(en_status[0]), .sel_A(sel_A[0]),
      .sel_B(sel_B[0]), .shift_op(shift_op[0]), .ALU_op(ALU_op[0]),
      .sximm8(sximm8[0]), .sximm5(sximm5[0]), .halted(halted[0])
   );

   cpu_controller #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
      .load_ir(load_ir[1]), .en_pc(en_pc[1]), .clr_pc(clr_pc[1]),
      .addr_sel(addr_sel[1]), .load_addr(load_addr[1]), .mem_rd(mem_rd[1]),
      .mem_wr(mem_wr[1]), .w_addr(w_addr[1]), .r_addr(r_addr[1]),
      .w_en(w_en[1]), .wb_sel(wb_sel[1]), .en_A(en_A[1]), .en_B(en_B[1]),
      .en_C(en_C[1]), .en_status(en_status[1]), .sel_A(sel_A[1]),
      .sel_B(sel_B[1]), .shift_op(shift_op[1]), .ALU_op(ALU_op[1]),
      .sximm8(sximm8[1]), .sximm5(sximm5[1]), .halted(halted[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outs_t got(input int unsigned k);
      return {load_ir[k], en_pc[k], clr_pc[k], addr_sel[k], load_addr[k],
              mem_rd[k], mem_wr[k], w_addr[k], r_addr[k], w_en[k], wb_sel[k],
              en_A[k], en_B[k], en_C[k], en_status[k], sel_A[k], sel_B[k],
              shift_op[k], ALU_op[k], sximm8[k], sximm5[k], halted[k]};
   endfunction

   // all-quiet output vector for a given IR value
   function automatic outs_t base(input logic [15:0] i);
      outs_t o;
      int    v8, v5;
      o  = '0;
      v8 = int'(i[7:0]);
      v5 = int'(i[4:0]);
      if (v8 >= 128) v8 = v8 - 256;
      if (v5 >= 16)  v5 = v5 - 32;
      o.sximm8 = 16'(v8);
      o.sximm5 = 16'(v5);
      return o;
   endfunction

   function automatic outs_t rst_rec(input logic [15:0] i);
      outs_t o;
      o        = base(i);
      o.clr_pc = 1'b1;
      o.en_pc  = 1'b1;
      return o;
   endfunction

   function automatic outs_t halt_rec(input logic [15:0] i);
      outs_t o;
      o        = base(i);
      o.halted = 1'b1;
      return o;
   endfunction

   task automatic push(input outs_t e0, input outs_t e1, input string tag);
      exp_t x;
      x.e0  = e0;
      x.e1  = e1;
      x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic cyc(input logic r, input logic [15:0] i, input logic rdy,
                      input outs_t e0, input outs_t e1, input string tag);
      @(posedge clk);
      #1;
      rst_n     = r;
      instr     = i;
      mem_ready = rdy;
      push(e0, e1, tag);
   endtask

   task automatic same(input logic [15:0] i, input logic rdy, input outs_t o,
                       input string tag);
      cyc(1'b1, i, rdy, o, o, tag);
   endtask

   task automatic do_reset(input logic [15:0] i);
      cyc(1'b0, i, 1'b0, rst_rec(i), rst_rec(i), "RST_LOW");
      cyc(1'b0, i, 1'b1, rst_rec(i), rst_rec(i), "RST_LOW");
      cyc(1'b1, i, 1'b0, rst_rec(i), rst_rec(i), "RST");
   endtask

   task automatic fetch_decode(input logic [15:0] i, input int unsigned fw);
      outs_t o;
      o          = base(i);
      o.addr_sel = 1'b1;
      o.mem_rd   = 1'b1;
      for (int unsigned w = 0; w < fw; w++) same(i, 1'b0, o, "FETCH_WAIT");
      o.load_ir = 1'b1;
      o.en_pc   = 1'b1;
      same(i, 1'b1, o, "FETCH");
      same(i, 1'($urandom_range(0, 1)), base(i), "DECODE");
   endtask

   // Reference sequencing, written directly from the per-instruction
   // step lists. abort_wr stops after the first MEM_WR wait cycle.
   task automatic run_instr(input logic [15:0] i, input int unsigned fw,
                            input int unsigned mw, input bit abort_wr);
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] op, sh;
      outs_t      o;
      opc = i[15:13]; op = i[12:11]; rn = i[10:8];
      rd  = i[7:5];   sh = i[4:3];   rm = i[2:0];
      fetch_decode(i, fw);
      if (opc == 3'b110 && op == 2'b10) begin
         o = base(i); o.w_addr = rn; o.wb_sel = 2'b10; o.w_en = 1'b1;
         same(i, 1'($urandom_range(0, 1)), o, "WB_IMM");
      end else if (opc == 3'b110 || opc == 3'b101) begin
         if (opc == 3'b101) begin
            o = base(i); o.r_addr = rn; o.en_A = 1'b1;
            same(i, 1'($urandom_range(0, 1)), o, "GET_A");
         end
         o = base(i); o.r_addr = rm; o.en_B = 1'b1;
         same(i, 1'($urandom_range(0, 1)), o, "GET_B");
         o = base(i); o.shift_op = sh;
         if (opc == 3'b101) begin
            o.sel_A  = 1'b1;
            o.ALU_op = op;
         end
         if (opc == 3'b101 && op == 2'b01) o.en_status = 1'b1;
         else                              o.en_C      = 1'b1;
         same(i, 1'($urandom_range(0, 1)), o, "EXEC");
         if (!(opc == 3'b101 && op == 2'b01)) begin
            o = base(i); o.w_addr = rd; o.w_en = 1'b1;
            same(i, 1'($urandom_range(0, 1)), o, "WB");
         end
      end else begin
         o = base(i); o.r_addr = rn; o.en_A = 1'b1;
         same(i, 1'($urandom_range(0, 1)), o, "GET_A");
         o = base(i); o.sel_A = 1'b1; o.sel_B = 1'b1; o.en_C = 1'b1;
         same(i, 1'($urandom_range(0, 1)), o, "ADDR");
         o = base(i); o.load_addr = 1'b1;
         same(i, 1'($urandom_range(0, 1)), o, "LD_ADDR");
         if (opc == 3'b011) begin
            o = base(i); o.mem_rd = 1'b1;
            for (int unsigned w = 0; w < mw; w++) same(i, 1'b0, o, "MEM_RD_WAIT");
            o.w_en = 1'b1; o.wb_sel = 2'b11; o.w_addr = rd;
            same(i, 1'b1, o, "MEM_RD");
         end else begin
            o = base(i); o.r_addr = rd; o.en_B = 1'b1;
            same(i, 1'($urandom_range(0, 1)), o, "GET_D");
            o = base(i); o.en_C = 1'b1;
            same(i, 1'($urandom_range(0, 1)), o, "MOV_D");
            o = base(i); o.mem_wr = 1'b1;
            if (abort_wr) begin
               same(i, 1'b0, o, "MEM_WR_WAIT");
            end else begin
               for (int unsigned w = 0; w < mw; w++) same(i, 1'b0, o, "MEM_WR_WAIT");
               same(i, 1'b1, o, "MEM_WR");
            end
         end
      end
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 4))
         0: r[15:11] = 5'b110_10;
         1: r[15:11] = 5'b110_00;
         2: r[15:13] = 3'b101;
         3: r[15:11] = 5'b011_00;
         default: r[15:11] = 5'b100_00;
      endcase
      return r;
   endfunction

   // monitor: every cycle both instances present a full control vector
   initial begin
      exp_t  x;
      outs_t g, e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            for (int unsigned k = 0; k < 2; k++) begin
               g = got(k);
               e = (k == 0) ? x.e0 : x.e1;
               total++;
               if (g !== e) begin
                  bad++;
                  $display("FAIL %s dut%0d got=%h exp=%h", x.tag, k, g, e);
               end
            end
         end
      end
   end

   initial begin
      outs_t o0, o1;
      rst_n     = 1'b0;
      instr     = 16'h0000;
      mem_ready = 1'b0;
      do_reset(16'h0000);

      run_instr(16'hD1FE, 0, 0, 1'b0);
      run_instr(16'hA049, 0, 0, 1'b0);
      run_instr(16'hA801, 1, 0, 1'b0);
      run_instr(16'h607F, 0, 3, 1'b0);
      run_instr(16'h8224, 2, 1, 1'b0);

      for (int unsigned n = 0; n < 60; n++)
         run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

      // illegal encoding: one instance halts, the other refetches
      fetch_decode(16'h2000, 0);
      o1 = base(16'h2000); o1.addr_sel = 1'b1; o1.mem_rd = 1'b1;
      cyc(1'b1, 16'h2000, 1'b0, halt_rec(16'h2000), o1, "ILLEGAL_NEXT");
      cyc(1'b1, 16'h2000, 1'b0, halt_rec(16'h2000), o1, "ILLEGAL_NEXT");
      do_reset(16'h2000);

      fetch_decode(16'hE000, 1);
      for (int unsigned n = 0; n < 12; n++)
         same(16'hE000, 1'($urandom_range(0, 1)), halt_rec(16'hE000), "HALT");
      do_reset(16'hE000);

      // asynchronous reset in the middle of a MEM_WR wait
      run_instr(16'h8224, 0, 0, 1'b1);
      @(posedge clk);
      #1;
      for (int unsigned k = 0; k < 2; k++) begin
         total++;
         if (mem_wr[k] !== 1'b1) begin
            bad++;
            $display("FAIL mem_wr_before_reset dut%0d got=%b exp=1", k, mem_wr[k]);
         end
      end
      rst_n = 1'b0;
      #1;
      for (int unsigned k = 0; k < 2; k++) begin
         total++;
         if (mem_wr[k] !== 1'b0 || clr_pc[k] !== 1'b1 || en_pc[k] !== 1'b1) begin
            bad++;
            $display("FAIL mem_wr_async_drop dut%0d got mem_wr=%b clr_pc=%b en_pc=%b exp 0/1/1",
                     k, mem_wr[k], clr_pc[k], en_pc[k]);
         end
      end
      o0 = rst_rec(16'h8224);
      push(o0, o0, "RST_ASYNC");
      cyc(1'b1, 16'h8224, 1'b0, o0, o0, "RST");
      run_instr(16'hD305, 0, 0, 1'b0);

      repeat (3) @(posedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multi-cycle control FSM for the 16-bit RISC core: the opposite end of the datapath control interface.
- Fetches an instruction into the IR, decodes it, and sequences every datapath control input (regfile ports, A/B/C enables, operand selects, shift/ALU op, status enable, writeback select) plus PC/IR/address-register loads and the memory read/write handshake.
- Also produces the sign-extended immediates sximm8/sximm5 consumed by the datapath.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = an undefined encoding enters HALT; 0 = it is treated as a NOP (DECODE -> FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  16  current IR contents.
- mem_ready  in  1  memory completes the pending read/write in this cycle.
- load_ir  out  1  IR <= mdata.
- en_pc  out  1  PC load enable.
- clr_pc  out  1  with en_pc: PC <= 0, else PC <= PC+1.
- addr_sel  out  1  1 = memory address from PC, 0 = from data-address register.
- load_addr  out  1  data-address register <= datapath_out[7:0].
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request; write data = datapath_out.
- w_addr, r_addr  out  3 each  regfile write/read addresses.
- w_en  out  1  regfile write enable.
- wb_sel  out  2  00 = C, 01 = {8'b0,pc}, 10 = sximm8, 11 = mdata.
- en_A, en_B, en_C, en_status  out  1 each  datapath register enables.
- sel_A  out  1  1 = A, 0 = zero.
- sel_B  out  1  1 = sximm5, 0 = shifted B.
- shift_op  out  2  shifter op.
- ALU_op  out  2  00 ADD, 01 SUB (CMP), 10 AND, 11 MVN.
- sximm8, sximm5  out  16 each  sign-extended instr[7:0], instr[4:0].
- halted  out  1  FSM in HALT.

Behaviour:
- Fields: opcode = instr[15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0].
- Encodings: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/op ALU (00 ADD, 01 CMP, 10 AND, 11 MVN); 011/00 LDR Rd,[Rn,#imm5]; 100/00 STR Rd,[Rn,#imm5]; 111 HALT. All other encodings are illegal.
- Outputs are a combinational function of state, instr and mem_ready. Any output not listed for a state is 0. sximm8/sximm5 always track instr.
- Reset: rst_n low asynchronously forces state RST from any state, including mid memory access; mem_rd/mem_wr drop immediately.
- RST: clr_pc = en_pc = 1, all else 0 -> FETCH.
- FETCH: addr_sel = mem_rd = 1. Hold while mem_ready = 0. On mem_ready = 1: load_ir = en_pc = 1 (PC+1) -> DECODE.
- DECODE: no enables. MOV-imm -> WB_IMM; MOV-reg -> GET_B; ALU, LDR, STR -> GET_A; HALT -> HALT; illegal -> HALT or FETCH per HALT_ON_ILLEGAL.
- WB_IMM: w_addr = Rn, wb_sel = 10, w_en -> FETCH.
- GET_A: r_addr = Rn, en_A. ALU -> GET_B; LDR/STR -> ADDR.
- GET_B: r_addr = Rm, en_B -> EXEC.
- EXEC: sel_B = 0, shift_op = sh.
  - MOV-reg: sel_A = 0, ALU_op = 00.
  - ALU: sel_A = 1, ALU_op = op.
  - CMP: en_status = 1, en_C = 0 -> FETCH. All others: en_C = 1 -> WB.
- WB: w_addr = Rd, wb_sel = 00, w_en -> FETCH.
- ADDR: sel_A = 1, sel_B = 1, ALU_op = 00, en_C -> LD_ADDR.
- LD_ADDR: load_addr. LDR -> MEM_RD; STR -> GET_D.
- MEM_RD: addr_sel = 0, mem_rd = 1, held until mem_ready. In the mem_ready cycle: w_en, wb_sel = 11, w_addr = Rd -> FETCH.
- GET_D: r_addr = Rd, en_B -> MOV_D.
- MOV_D: sel_A = 0, sel_B = 0, shift_op = 00, ALU_op = 00, en_C -> MEM_WR.
- MEM_WR: addr_sel = 0, mem_wr = 1, held until mem_ready -> FETCH.
- HALT: halted = 1; sticky until rst_n.
- Never assert mem_rd and mem_wr together. w_en is never asserted outside WB_IMM, WB and the MEM_RD ready cycle.
- Latency with zero-wait memory: MOV-imm 3 cycles, MOV-reg 5, ALU 6, CMP 5, LDR 6, STR 8.

Decomposition:
- Package risc_pkg: opcode and op constants, ALU_op and wb_sel encodings, state_t enum (RST, FETCH, DECODE, WB_IMM, GET_A, GET_B, EXEC, WB, ADDR, LD_ADDR, MEM_RD, GET_D, MOV_D, MEM_WR, HALT).
- One sub-module, instr_dec: combinational field extraction, sign extension and legal/illegal classification.

Test Plan:
- instr = 0xD1FE, mem_ready = 1 -> DECODE, then WB_IMM with w_addr = 1, wb_sel = 10, w_en = 1, sximm8 = 0xFFFE; back in FETCH 3 cycles after FETCH.
- instr = 0xA049 (ADD R2,R0,R1 LSL) -> GET_A r_addr = 0/en_A; GET_B r_addr = 1/en_B; EXEC sel_A = 1, sel_B = 0, shift_op = 01, ALU_op = 00, en_C = 1, en_status = 0; WB w_addr = 2, wb_sel = 00.
- instr = 0xA801 (CMP R0,R1) -> EXEC ALU_op = 01, en_status = 1, en_C = 0, then FETCH; w_en never asserted.
- instr = 0x607F (LDR R3,[R0,#-1]), mem_ready low 3 cycles in MEM_RD -> sximm5 = 0xFFFF; ADDR sel_B = 1; mem_rd = 1, addr_sel = 0 for 4 cycles; w_en = 1, wb_sel = 11, w_addr = 3 only in the ready cycle.
- instr = 0x8224 (STR R1,[R2,#4]) -> GET_A r_addr = 2; LD_ADDR load_addr = 1; GET_D r_addr = 1; MEM_WR mem_wr = 1, addr_sel = 0, mem_rd = 0; w_en never asserted.
- instr = 0xE000 -> halted = 1 held 10+ cycles. Then rst_n low mid-MEM_WR on a later STR -> mem_wr drops immediately; after release RST asserts clr_pc = en_pc = 1, then FETCH. instr = 0x2000 with HALT_ON_ILLEGAL = 0 -> DECODE -> FETCH.
